zmod_align_ctrl: RTL and testbench
==================================

ZMOD_ALIGN_CTRL -- requirements
Module: zmod_align_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16: consecutive valid markers required to lock (range 2..255).
REQ-002 SHALL have parameter UNLOCK_CNT, default 4: consecutive bad markers required to drop lock (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock, the receive divided clock (rxdivclk domain); all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  alignment enable; low forces the hunt state.
REQ-006 SHALL have port rx_marker  input  8  raw lane-3 byte from the deserializer, sampled every cycle.
REQ-007 SHALL have port shift  output  3  bit-rotation amount applied to all lanes by the framing datapath.
REQ-008 SHALL have port locked  output  1  framing valid.
REQ-009 SHALL have port lock_lost  output  1  one-cycle pulse when lock drops due to errors.
REQ-010 SHALL have port err_cnt  output  16  saturating count of bad markers seen while locked.
REQ-011 SHALL have port relock_cnt  output  8  saturating count of lock_lost events.

Function
REQ-012 SHALL implement a three-state FSM: HUNT, VERIFY, LOCKED; all outputs registered.
REQ-013 SHALL treat a marker as one-hot when exactly one bit of rx_marker is set; index = position of that bit (0x01->0 ... 0x80->7).
REQ-014 HUNT: en=1 and rx_marker one-hot -> cand<=index, match count<=1, go VERIFY; otherwise stay in HUNT.
REQ-015 VERIFY: rx_marker == (1<<cand) -> match count +1; when this is the LOCK_CNT-th consecutive match -> shift<=cand, locked<=1, go LOCKED.
REQ-016 VERIFY: any other rx_marker (including a different one-hot value) -> match count<=0, go HUNT; no restart in the same cycle.
REQ-017 locked SHALL rise on the clock edge that samples the LOCK_CNT-th consecutive matching marker (first observable next cycle); minimum HUNT->locked latency = LOCK_CNT cycles.
REQ-018 LOCKED: rx_marker == (1<<shift) -> bad count<=0; otherwise bad count +1 and err_cnt +1.
REQ-019 LOCKED: bad marker that is the UNLOCK_CNT-th consecutive -> locked<=0, lock_lost=1 for exactly one cycle, relock_cnt +1, go HUNT.
REQ-020 A single good marker in LOCKED SHALL clear the bad count (errors need not be contiguous to count in err_cnt, only to unlock).
REQ-021 en=0 in any state SHALL go HUNT next cycle, clear match/bad counts, drive locked=0, and SHALL NOT pulse lock_lost or change counters.
REQ-022 shift SHALL only change on VERIFY->LOCKED; it holds its last value in HUNT/VERIFY.
REQ-023 err_cnt SHALL saturate at 0xFFFF and relock_cnt at 0xFF; no wrap.
REQ-024 In LOCKED, an error on the same cycle as en falling SHALL be ignored (en has priority).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=HUNT, shift=0, locked=0, lock_lost=0, err_cnt=0, relock_cnt=0, internal counts=0.
REQ-026 Reset asserted mid-VERIFY or mid-LOCKED SHALL take effect immediately with no lock_lost pulse; operation resumes in HUNT on the first edge after release.

Configuration
REQ-027 Macro ZMOD_ALIGN_STATS_EN defined: err_cnt and relock_cnt counters SHALL be implemented as specified.
REQ-028 Macro ZMOD_ALIGN_STATS_EN undefined: err_cnt and relock_cnt SHALL be constant 0 with no counter logic; FSM, shift, locked, lock_lost unchanged.

Verification
REQ-029 Reset, en=1, rx_marker=0x04 constant -> locked=1 exactly 16 cycles after first sample, shift=2, err_cnt=0.
REQ-030 Locked at shift=2, inject 3 cycles rx_marker=0x08 then 0x04 -> locked stays 1, err_cnt=3, relock_cnt=0, no lock_lost.
REQ-031 Locked at shift=2, inject 4 consecutive 0x00 -> lock_lost pulses one cycle on 4th, locked=0, relock_cnt=1, err_cnt=4; then 16 x 0x10 -> locked=1, shift=4.
REQ-032 In VERIFY, 10 x 0x01 then one 0x03 then 16 x 0x01 -> no lock until 16 clean samples after the 0x03 (non-one-hot resets hunt).
REQ-033 Locked, drop en for one cycle -> locked=0 next cycle, no lock_lost, counters unchanged; re-lock after 16 good markers; repeat with rst_n pulse mid-LOCKED -> all outputs 0 immediately.
REQ-034 With ZMOD_ALIGN_STATS_EN, force 70000 bad markers with UNLOCK_CNT=255 and interleaved good ones -> err_cnt holds 0xFFFF; without macro, err_cnt=relock_cnt=0 throughout.

Source files
------------

// File: rtl/zmod_align_ctrl.sv
// Lane-3 marker alignment FSM (HUNT/VERIFY/LOCKED) producing the framing bit-rotation.
// Outputs one cycle after the sampling edge; no backpressure. Stats counters only with ZMOD_ALIGN_STATS_EN.
module zmod_align_ctrl #(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  rx_marker,
  output logic [2:0]  shift,
  output logic        locked,
  output logic        lock_lost,
  output logic [15:0] err_cnt,
  output logic [7:0]  relock_cnt
);

  localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [2:0] cand_q, cand_d;
  logic [2:0] shift_q, shift_d;
  logic [7:0] match_q, match_d;
  logic [7:0] bad_q, bad_d;
  logic       locked_q, locked_d;
  logic       lock_lost_q, lock_lost_d;
`ifdef ZMOD_ALIGN_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [7:0]  relock_cnt_q, relock_cnt_d;
`endif

  logic       onehot;
  logic [2:0] idx;
  logic       cand_hit;
  logic       shift_hit;

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (rx_marker[i]) idx = 3'(i);
    end
    onehot    = (rx_marker != 8'd0) && ((rx_marker & (rx_marker - 8'd1)) == 8'd0);
    cand_hit  = (rx_marker == (8'd1 << cand_q));
    shift_hit = (rx_marker == (8'd1 << shift_q));
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    shift_d     = shift_q;
    match_d     = match_q;
    bad_d       = bad_q;
    locked_d    = locked_q;
    lock_lost_d = 1'b0;
`ifdef ZMOD_ALIGN_STATS_EN
    err_cnt_d    = err_cnt_q;
    relock_cnt_d = relock_cnt_q;
`endif
    // Disable wins over any marker error seen in the same cycle.
    if (!en) begin
      state_d  = HUNT;
      match_d  = '0;
      bad_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (onehot) begin
            cand_d  = idx;
            match_d = 8'd1;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (cand_hit) begin
            if (match_q + 8'd1 == LOCK_N) begin
              shift_d  = cand_q;
              locked_d = 1'b1;
              match_d  = '0;
              bad_d    = '0;
              state_d  = LOCKED;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            match_d = '0;
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (shift_hit) begin
            bad_d = '0;
          end else begin
`ifdef ZMOD_ALIGN_STATS_EN
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
            if (bad_q + 8'd1 == UNLOCK_N) begin
              bad_d       = '0;
              locked_d    = 1'b0;
              lock_lost_d = 1'b1;
              state_d     = HUNT;
`ifdef ZMOD_ALIGN_STATS_EN
              if (relock_cnt_q != 8'hFF) relock_cnt_d = relock_cnt_q + 8'd1;
`endif
            end else begin
              bad_d = bad_q + 8'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cand_q      <= '0;
      shift_q     <= '0;
      match_q     <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
`ifdef ZMOD_ALIGN_STATS_EN
      err_cnt_q    <= '0;
      relock_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      shift_q     <= shift_d;
      match_q     <= match_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
`ifdef ZMOD_ALIGN_STATS_EN
      err_cnt_q    <= err_cnt_d;
      relock_cnt_q <= relock_cnt_d;
`endif
    end
  end

  assign shift     = shift_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;
`ifdef ZMOD_ALIGN_STATS_EN
  assign err_cnt    = err_cnt_q;
  assign relock_cnt = relock_cnt_q;
`else
  assign err_cnt    = '0;
  assign relock_cnt = '0;
`endif

endmodule

// File: tb/tb_zmod_align_ctrl.sv
// Directed bench for zmod_align_ctrl: lock, error tolerance, unlock, enable/reset behaviour, counter saturation.
module tb_zmod_align_ctrl;

`ifdef ZMOD_ALIGN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  rx_marker = 8'd0;
  logic [7:0]  mk2 = 8'd0;
  logic [2:0]  shift, shift2;
  logic        locked, locked2;
  logic        lock_lost, lock_lost2;
  logic [15:0] err_cnt, err_cnt2;
  logic [7:0]  relock_cnt, relock_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  zmod_align_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_marker(rx_marker),
    .shift(shift), .locked(locked), .lock_lost(lock_lost),
    .err_cnt(err_cnt), .relock_cnt(relock_cnt)
  );

  zmod_align_ctrl #(.LOCK_CNT(16), .UNLOCK_CNT(255)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_marker(mk2),
    .shift(shift2), .locked(locked2), .lock_lost(lock_lost2),
    .err_cnt(err_cnt2), .relock_cnt(relock_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive a marker, let one edge sample it, then observe 1 time unit later.
  task automatic tick(input logic [7:0] m);
    rx_marker = m;
    @(posedge clk);
    #1;
  endtask

  task automatic tick2(input logic [7:0] m);
    mk2 = m;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input logic [7:0] m, input int n);
    for (int i = 0; i < n; i++) tick(m);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    rx_marker = 8'd0;
    mk2   = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int nb;
    apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_shift", 32'(shift), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_relock", 32'(relock_cnt), 0);
    rst_n = 1'b1;

    // Constant 0x04: locked after exactly 16 samples.
    ticks(8'h04, 15);
    chk("lock_not_before_16", 32'(locked), 0);
    tick(8'h04);
    chk("lock_at_16", 32'(locked), 1);
    chk("lock_shift2", 32'(shift), 2);
    chk("lock_err0", 32'(err_cnt), 0);

    // Three wrong one-hot markers then a good one: stay locked.
    for (int i = 0; i < 3; i++) begin
      tick(8'h08);
      chk("tol_locked", 32'(locked), 1);
      chk("tol_no_lost", 32'(lock_lost), 0);
    end
    tick(8'h04);
    chk("tol_locked_after", 32'(locked), 1);
    chk("tol_err3", 32'(err_cnt), STATS ? 3 : 0);
    chk("tol_relock0", 32'(relock_cnt), 0);

    // Fresh lock, then four 0x00 drop it; relock at shift 4.
    apply_reset();
    ticks(8'h04, 16);
    chk("ul_locked", 32'(locked), 1);
    ticks(8'h00, 3);
    chk("ul_still_locked", 32'(locked), 1);
    chk("ul_no_lost_yet", 32'(lock_lost), 0);
    tick(8'h00);
    chk("ul_lost_pulse", 32'(lock_lost), 1);
    chk("ul_unlocked", 32'(locked), 0);
    chk("ul_relock1", 32'(relock_cnt), STATS ? 1 : 0);
    chk("ul_err4", 32'(err_cnt), STATS ? 4 : 0);
    tick(8'h10);
    chk("ul_lost_one_cycle", 32'(lock_lost), 0);
    ticks(8'h10, 14);
    chk("ul_relock_not_yet", 32'(locked), 0);
    chk("ul_shift_held", 32'(shift), 2);
    tick(8'h10);
    chk("ul_relocked", 32'(locked), 1);
    chk("ul_shift4", 32'(shift), 4);

    // Non-one-hot marker in VERIFY restarts the hunt.
    apply_reset();
    ticks(8'h20, 10);
    tick(8'h03);
    chk("nh_unlocked", 32'(locked), 0);
    ticks(8'h20, 15);
    chk("nh_not_yet", 32'(locked), 0);
    tick(8'h20);
    chk("nh_locked", 32'(locked), 1);
    chk("nh_shift5", 32'(shift), 5);

    // Two errors, then en drop coinciding with a third error.
    ticks(8'h02, 2);
    en = 1'b0;
    tick(8'h00);
    chk("en_unlocked", 32'(locked), 0);
    chk("en_no_lost", 32'(lock_lost), 0);
    chk("en_err_kept", 32'(err_cnt), STATS ? 2 : 0);
    chk("en_relock_kept", 32'(relock_cnt), 0);
    en = 1'b1;
    ticks(8'h20, 15);
    chk("en_relock_not_yet", 32'(locked), 0);
    tick(8'h20);
    chk("en_relocked", 32'(locked), 1);
    // Bad count was cleared by en drop: three more errors must not unlock.
    ticks(8'h00, 3);
    chk("en_bad_cleared", 32'(locked), 1);
    chk("en_err5", 32'(err_cnt), STATS ? 5 : 0);
    tick(8'h20);

    // Asynchronous reset mid-LOCKED.
    rst_n = 1'b0;
    #2;
    chk("ar_locked", 32'(locked), 0);
    chk("ar_shift", 32'(shift), 0);
    chk("ar_err", 32'(err_cnt), 0);
    chk("ar_lost", 32'(lock_lost), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(8'h20);
    chk("ar_hunt_after", 32'(locked), 0);
    chk("ar_no_lost_after", 32'(lock_lost), 0);

    // Saturation: UNLOCK_CNT=255, 70000 bad markers, a good one every 200.
    apply_reset();
    for (int i = 0; i < 16; i++) tick2(8'h01);
    chk("sat_locked", 32'(locked2), 1);
    nb = 0;
    while (nb < 70000) begin
      for (int k = 0; k < 200 && nb < 70000; k++) begin
        tick2(8'h00);
        nb++;
        if (nb == 65534) chk("sat_err_65534", 32'(err_cnt2), STATS ? 32'hFFFE : 0);
        if (nb == 65535) chk("sat_err_65535", 32'(err_cnt2), STATS ? 32'hFFFF : 0);
      end
      tick2(8'h01);
    end
    chk("sat_err_hold", 32'(err_cnt2), STATS ? 32'hFFFF : 0);
    chk("sat_still_locked", 32'(locked2), 1);
    chk("sat_relock0", 32'(relock_cnt2), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
